// File: rtl/shared_dff_arbiter.sv
// Round-robin arbiter that lends one shared DATA_W-bit register to NUM_REQ requesters.
// Define SHARED_DFF_ARBITER_TIMEOUT_EN to bound a tenure at MAX_HOLD cycles under contention.
module shared_dff_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  di,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [DATA_W-1:0]          dout,
    output logic                       upd
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n, owner_n, win, idx;
    logic [NUM_REQ-1:0] gnt_n;
    logic [DATA_W-1:0]  dout_n, own_di;
    logic               found, written, written_n, upd_n, release_now;
    int                 j;

`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] others;
    logic               at_max;

    assign others = req & ~(NUM_REQ'(1) << owner);
    assign at_max = (cnt == CNT_W'(MAX_HOLD - 1));
`endif

    assign own_di = di[owner*DATA_W +: DATA_W];

    // First requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = IDX_W'(j);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        owner_n     = owner;
        ptr_n       = ptr;
        dout_n      = dout;
        upd_n       = 1'b0;
        written_n   = written;
        release_now = 1'b0;
`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
        cnt_n       = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n   = GRANT;
                    gnt_n     = NUM_REQ'(1) << win;
                    owner_n   = win;
                    ptr_n     = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    written_n = 1'b0;
`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
                    cnt_n     = '0;
`endif
                end
            end
            GRANT: begin
                if (req[owner]) begin
                    dout_n    = own_di;
                    upd_n     = ~written;
                    written_n = 1'b1;
`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
                    // A saturated owner is only evicted if someone else is waiting.
                    if (at_max) begin
                        if (|others) release_now = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
`endif
                end else begin
                    release_now = 1'b1;
                end
                if (release_now) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    owner_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            dout    <= '0;
            upd     <= 1'b0;
            written <= 1'b0;
`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            dout    <= dout_n;
            upd     <= upd_n;
            written <= written_n;
`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
            cnt     <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// Scoreboard testbench for shared_dff_arbiter: a behavioural model queues expected
// outputs per cycle, plus directed checks for reset, rotation, wrap and hold scenarios.
module tb_shared_dff_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] di  = '0;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  dout;
    logic        upd;

    always #5 clk = ~clk;

    shared_dff_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .di   (di),
        .gnt  (gnt),
        .owner(owner),
        .dout (dout),
        .upd  (upd)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [7:0] dout;
        logic       upd;
    } exp_t;

    exp_t sbq[$];
    int   checkCount = 0;
    int   passCount  = 0;

    bit         m_busy  = 1'b0;
    logic [3:0] m_gnt   = '0;
    logic [1:0] m_owner = '0;
    logic [1:0] m_ptr   = '0;
    logic [7:0] m_dout  = '0;
    logic       m_upd   = 1'b0;
    logic       m_first = 1'b0;
    int         m_cnt   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        else
            passCount++;
    endtask

    task modelRelease();
        m_busy  = 1'b0;
        m_gnt   = '0;
        m_owner = '0;
    endtask

    // Advance the reference model by one clock edge using the inputs now being driven.
    task modelStep();
        bit         found;
        int         k;
        logic [3:0] others;
        exp_t       e;
        m_upd = 1'b0;
        if (rst) begin
            modelRelease();
            m_ptr   = '0;
            m_dout  = '0;
            m_first = 1'b0;
            m_cnt   = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                k = (int'(m_ptr) + i) % NUM_REQ;
                if (!found && req[k]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_gnt   = 4'(1 << k);
                    m_owner = 2'(k);
                    m_ptr   = 2'((k + 1) % NUM_REQ);
                    m_cnt   = 0;
                    m_first = 1'b1;
                end
            end
        end else if (req[m_owner]) begin
            m_dout  = di[m_owner*8 +: 8];
            m_upd   = m_first;
            m_first = 1'b0;
`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
            others = req;
            others[m_owner] = 1'b0;
            if (m_cnt == MAX_HOLD - 1) begin
                if (others != 0) modelRelease();
            end else begin
                m_cnt++;
            end
`else
            others = '0;
`endif
        end else begin
            modelRelease();
        end
        e.gnt   = m_gnt;
        e.owner = m_owner;
        e.dout  = m_dout;
        e.upd   = m_upd;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic r_rst, input logic [3:0] r, input logic [31:0] d);
        exp_t e;
        rst = r_rst;
        req = r;
        di  = d;
        modelStep();
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checkOutput("sb_gnt",   32'(gnt),   32'(e.gnt));
        checkOutput("sb_owner", 32'(owner), 32'(e.owner));
        checkOutput("sb_dout",  32'(dout),  32'(e.dout));
        checkOutput("sb_upd",   32'(upd),   32'(e.upd));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        logic [3:0]  order[$];
        logic [3:0]  lastGnt;
        logic [3:0]  expOrder[5];
        int          tenure, zeroRun, updCount;

        // Reset held with every requester active.
        applyStimulus(1'b1, 4'b1111, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 4'b1111, 32'hFFFF_FFFF);
        checkOutput("rst_gnt",  32'(gnt),  32'h0);
        checkOutput("rst_dout", 32'(dout), 32'h0);
        applyStimulus(1'b0, 4'b1111, 32'h0);
        checkOutput("first_gnt", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 4'b0000, 32'h0);

        // Single requester on slot 2.
        updCount = 0;
        applyStimulus(1'b0, 4'b0100, 32'h00A5_0000);
        checkOutput("single_gnt", 32'(gnt), 32'h4);
        applyStimulus(1'b0, 4'b0100, 32'h00A5_0000);
        checkOutput("single_dout", 32'(dout), 32'hA5);
        updCount += int'(upd);
        applyStimulus(1'b0, 4'b0100, 32'h00A5_0000);
        updCount += int'(upd);
        checkOutput("single_upd_once", 32'(updCount), 32'd1);
        applyStimulus(1'b0, 4'b0000, 32'h003C_0000);
        checkOutput("release_gnt",  32'(gnt),  32'h0);
        checkOutput("release_dout", 32'(dout), 32'hA5);

        // Rotation with all requesters active, each owner leaving after 3 cycles.
        applyStimulus(1'b1, 4'b1111, 32'h0);
        tenure  = 0;
        zeroRun = 0;
        lastGnt = '0;
        for (int s = 0; s < 40 && order.size() < 5; s++) begin
            r = 4'b1111;
            if (m_busy && tenure == 3) r[m_owner] = 1'b0;
            applyStimulus(1'b0, r, $urandom);
            tenure = m_busy ? tenure + 1 : 0;
            checkOutput("onehot0", 32'($onehot0(gnt)), 32'd1);
            if (gnt == 4'b0000) begin
                zeroRun++;
            end else if (gnt != lastGnt) begin
                if (order.size() > 0) checkOutput("dead_cycle", 32'(zeroRun), 32'd1);
                order.push_back(gnt);
                zeroRun = 0;
            end
            lastGnt = gnt;
        end
        expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        checkOutput("rot_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            checkOutput("rot_order", 32'(order[i]), 32'(expOrder[i]));

        // Wrap and skip: ptr parked at 3, requests on 0 and 2 only.
        applyStimulus(1'b1, 4'b0000, 32'h0);
        applyStimulus(1'b0, 4'b0100, 32'h0);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        applyStimulus(1'b0, 4'b0101, 32'h0011_0022);
        checkOutput("wrap_gnt0", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 4'b0101, 32'h0011_0022);
        applyStimulus(1'b0, 4'b0101, 32'h0011_0033);
        checkOutput("wrap_dout", 32'(dout), 32'h33);
        applyStimulus(1'b0, 4'b0100, 32'h0011_0044);
        checkOutput("wrap_release", 32'(gnt), 32'h0);
        applyStimulus(1'b0, 4'b0100, 32'h0011_0044);
        checkOutput("skip_gnt2", 32'(gnt), 32'h4);

`ifdef SHARED_DFF_ARBITER_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles while requester 1 waits.
        begin
            logic [3:0] expTo[6];
            logic [3:0] gotTo[6];
            expTo = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
            applyStimulus(1'b1, 4'b0000, 32'h0);
            applyStimulus(1'b0, 4'b0001, $urandom);
            gotTo[0] = gnt;
            for (int i = 1; i < 6; i++) begin
                applyStimulus(1'b0, 4'b0011, $urandom);
                gotTo[i] = gnt;
            end
            for (int i = 0; i < 6; i++)
                checkOutput("timeout_seq", 32'(gotTo[i]), 32'(expTo[i]));
        end
`endif

        // Lone requester holds for 40 cycles; dout tracks di with one cycle latency.
        applyStimulus(1'b1, 4'b0000, 32'h0);
        applyStimulus(1'b0, 4'b0001, 32'h0);
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            applyStimulus(1'b0, 4'b0001, d);
            checkOutput("hold_gnt",   32'(gnt),  32'h1);
            checkOutput("hold_track", 32'(dout), 32'(d[7:0]));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shared_dff_arbiter.md
# shared_dff_arbiter

Round-robin arbiter that shares one DATA_W-bit flip-flop register among NUM_REQ requesters. A requester holds `req` to own the register; while it owns the register, its `di` slice is captured into the shared register on every clock edge. The block sits between several producers and a single clocked storage stage. It provides one-hot grant, fair rotation and, optionally, a bounded hold time.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, width of the shared register
- MAX_HOLD, 16, maximum consecutive grant cycles when timeout is compiled in (≥2)
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- req  input  NUM_REQ  request per requester; held high for as long as ownership is wanted
- di  input  NUM_REQ*DATA_W  write data; requester i drives bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  registered one-hot grant, or all-zero
- owner  output  $clog2(NUM_REQ)  index of the current grantee; 0 when idle
- dout  output  DATA_W  shared register contents
- upd  output  1  one-cycle pulse: dout changed source on the previous edge

## Operation
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state (all outputs and state cleared):
  - State machine in IDLE.
  - gnt=0, owner=0, dout=0, upd=0.
  - Round-robin pointer ptr=0, hold counter cnt=0.
- IDLE:
  - If any req bit is high, grant the first set bit searching upward from ptr and wrapping modulo NUM_REQ.
  - On the grant: gnt[k]=1, owner=k, ptr=k+1 mod NUM_REQ, cnt=0; go to GRANT.
  - If no req bit is high, stay in IDLE.
- GRANT:
  - On each edge with req[owner]=1: dout <= di[owner]; cnt saturates at MAX_HOLD-1.
  - On the edge where req[owner]=0: clear gnt; go to IDLE. dout is not written on that edge and keeps its value.
- Dead cycle: IDLE always lasts at least one cycle after a release. gnt is all-zero for ≥1 cycle between owners.
- upd:
  - Asserted for one cycle after a GRANT edge where dout was written and it was the first write of that tenure.
  - Asserted only once per tenure, not on every write.
- Requests for unowned slots never alter dout.
- gnt is never a function of the current-cycle req; it is always registered.
- Reset mid-tenure:
  - gnt drops on the reset edge.
  - dout returns to 0.
  - ptr returns to 0.

## Timing
- Request to grant: req[k] first sampled high at edge n → gnt[k]=1 after edge n (visible in cycle n+1), provided the block was in IDLE and k wins arbitration.
- Capture latency: di[owner] present at edge m (with gnt and req high) → visible on dout after edge m. That is one cycle; there is no combinational path from di to dout.
- Release: req[owner] low at edge r → gnt=0 after edge r. The earliest next grant is after edge r+1.
- Simultaneous requests: the winner is the first index at or above ptr, wrapping. Example: ptr=2 with req=4'b1011 → grant 3.
- Wrap-around: ptr=NUM_REQ-1 with only req[0] high → grant 0 and ptr becomes 1.

## Configuration
- Macro `SHARED_DFF_ARBITER_TIMEOUT_EN`.
- Defined:
  - In GRANT, when cnt==MAX_HOLD-1 and any other req bit is high, the next edge forces a release.
  - On that edge, dout is still written with di[owner], then gnt clears and the block goes to IDLE; ptr is already past the owner.
  - If no other requester is pending, cnt saturates and the grant is kept indefinitely.
- Undefined:
  - cnt logic is removed.
  - The owner keeps the grant until it drops req; MAX_HOLD is ignored.

## Test plan
- Reset: hold rst high for 2 cycles with req=4'b1111 → gnt=0, dout=0, upd=0, owner=0 throughout; the first grant after reset falls is gnt=4'b0001.
- Single requester: req[2]=1 with di slice 2 = 8'hA5 → gnt=4'b0100 one cycle later, dout=8'hA5 the following cycle, upd pulses once. Drop req[2] → gnt=0 next cycle and dout holds 8'hA5.
- Rotation: req=4'b1111 held, each owner releases after 3 cycles → grant order 0,1,2,3,0 with exactly one gnt=0 cycle between owners; gnt is always one-hot or zero.
- Wrap and skip: ptr=3, req=4'b0101 → grant 0, then after its release grant 2; bits 1 and 3 are never granted.
- Timeout (macro defined, MAX_HOLD=4): req[0] held high, req[1] rises at cycle 1 → gnt[0] lasts exactly 4 cycles, then gnt[1] is asserted after one dead cycle.
- Timeout, no contention, or macro undefined: req[0] alone is held for 40 cycles → gnt[0] stays high all 40 cycles and dout tracks di slice 0 with 1-cycle latency.
